// File: rtl/alu_exec_16bit.sv
// alu_exec_16bit: execute stage between register-file read and write ports.
// Ports: clk, rst (async, active-high); in_valid/in_ready handshake; op, Rd,
// busA, busB in; Rw, WrEn, busW to the write port; ovf, zero flags.
module alu_exec_16bit #(
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    Rd,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic [AW-1:0]    Rw,
  output logic             WrEn,
  output logic [WIDTH-1:0] busW,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SW-1:0]    r_cnt;
  logic [AW-1:0]    r_rd;

  logic             w_accept;
  logic             w_wr;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_step;
  logic             w_last;
  logic [SW-1:0]    w_sh;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_sh     = busB[SW-1:0];
  assign w_sum    = busA + busB;
  assign w_diff   = busA - busB;
  // Partial product for this iteration folded in so the last edge
  // can write the finished product directly.
  assign w_step   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last   = (r_cnt == SW'(WIDTH - 1));

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_wr  = 1'b1;
    case (op)
      4'd0: begin
        w_res = w_sum;
        w_ovf = (busA[WIDTH-1] == busB[WIDTH-1]) &&
                (w_sum[WIDTH-1] != busA[WIDTH-1]);
      end
      4'd1: begin
        w_res = w_diff;
        w_ovf = (busA[WIDTH-1] != busB[WIDTH-1]) &&
                (w_diff[WIDTH-1] != busA[WIDTH-1]);
      end
      4'd2: w_res = busA & busB;
      4'd3: w_res = busA | busB;
      4'd4: w_res = busA ^ busB;
      4'd5: w_res = ~busA;
      4'd6: w_res = busA << w_sh;
      4'd7: w_res = busA >> w_sh;
      4'd8: w_res = $unsigned($signed(busA) >>> w_sh);
      4'd9: w_res = {{(WIDTH-1){1'b0}},
                     ($signed(busA) < $signed(busB))};
      default: w_wr = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && op == OP_MUL) w_next = S_MUL;
      S_MUL:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rd     <= '0;
      Rw       <= '0;
      WrEn     <= 1'b0;
      busW     <= '0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      r_state <= w_next;
      WrEn    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && op == OP_MUL) begin
            r_mcand  <= busA;
            r_mplier <= busB;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_rd     <= Rd;
          end else if (w_accept && w_wr) begin
            Rw   <= Rd;
            busW <= w_res;
            WrEn <= 1'b1;
            ovf  <= w_ovf;
            zero <= (w_res == '0);
          end
        end
        S_MUL: begin
          r_acc    <= w_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            busW <= w_step;
            Rw   <= r_rd;
            WrEn <= 1'b1;
            ovf  <= 1'b0;
            zero <= (w_step == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_16bit.sv
// tb_alu_exec_16bit: scoreboard bench for alu_exec_16bit.
// Directed cases followed by randomized ops against a reference model.
module tb_alu_exec_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  Rd;
  logic [15:0] busA;
  logic [15:0] busB;
  logic [4:0]  Rw;
  logic        WrEn;
  logic [15:0] busW;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rw;
    logic [15:0] w;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t q[$];

  alu_exec_16bit #(.WIDTH(16), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .Rd(Rd), .busA(busA), .busB(busB),
    .Rw(Rw), .WrEn(WrEn), .busW(busW),
    .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [4:0] d,
                                 input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    int sa;
    int sb;
    int r;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.rw = d;
    e.ovf = 1'b0;
    e.w = '0;
    case (o)
      4'd0: begin
        r = sa + sb;
        e.w = r[15:0];
        e.ovf = (r > 32767) || (r < -32768);
      end
      4'd1: begin
        r = sa - sb;
        e.w = r[15:0];
        e.ovf = (r > 32767) || (r < -32768);
      end
      4'd2: e.w = a & b;
      4'd3: e.w = a | b;
      4'd4: e.w = a ^ b;
      4'd5: e.w = ~a;
      4'd6: e.w = a << b[3:0];
      4'd7: e.w = a >> b[3:0];
      4'd8: begin
        r = sa >>> b[3:0];
        e.w = r[15:0];
      end
      4'd9: e.w = (sa < sb) ? 16'd1 : 16'd0;
      4'd10: begin
        p = longint'(a) * longint'(b);
        e.w = p[15:0];
      end
      default: e.w = '0;
    endcase
    e.zero = (e.w == 16'd0);
    return e;
  endfunction

  // Monitor: every write pulse must match the oldest pending expectation.
  int stall = 0;
  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
    end else begin
      if (WrEn) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: Rw=%0d busW=%h", Rw, busW);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({Rw, busW, ovf, zero} != e) begin
            errors++;
            $display("FAIL write: got Rw=%0d busW=%h ovf=%b zero=%b, want Rw=%0d busW=%h ovf=%b zero=%b",
                     Rw, busW, ovf, zero, e.rw, e.w, e.ovf, e.zero);
          end
        end
      end
      if (!in_ready) begin
        stall++;
      end else if (stall > 0) begin
        checks++;
        if (stall != 16) begin
          errors++;
          $display("FAIL mul_stall: got %0d cycles, want 16", stall);
        end
        stall = 0;
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Present one op, wait for acceptance; returns at the following negedge
  // with in_valid still high so back-to-back issue is possible.
  task automatic drive(input logic [3:0] o, input logic [4:0] d,
                       input logic [15:0] a, input logic [15:0] b,
                       input bit push, input bit lit,
                       input logic [15:0] w, input logic f);
    int n;
    exp_t e;
    in_valid = 1'b1;
    op = o;
    Rd = d;
    busA = a;
    busB = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
    end
    if (push) begin
      if (lit) begin
        e.rw = d;
        e.w = w;
        e.ovf = f;
        e.zero = (w == 16'd0);
      end else begin
        e = model(o, d, a, b);
      end
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] o, input logic [4:0] d,
                      input logic [15:0] a, input logic [15:0] b);
    drive(o, d, a, b, (o <= 4'd10), 1'b0, 16'd0, 1'b0);
  endtask

  task automatic sendx(input logic [3:0] o, input logic [4:0] d,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] w, input logic f);
    drive(o, d, a, b, 1'b1, 1'b1, w, f);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = '0;
    Rd = '0;
    busA = '0;
    busB = '0;
    #20;
    @(negedge clk);
    check("rst_wren", 32'(WrEn), 32'd0);
    check("rst_busw", 32'(busW), 32'd0);
    check("rst_rw", 32'(Rw), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;
    idle(2);

    sendx(4'd0, 5'd3, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    sendx(4'd1, 5'd4, 16'h0005, 16'h0005, 16'h0000, 1'b0);
    idle(2);

    sendx(4'd2, 5'd1, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0);
    sendx(4'd8, 5'd2, 16'h8000, 16'h0004, 16'hF800, 1'b0);
    sendx(4'd9, 5'd5, 16'hFFFF, 16'h0001, 16'h0001, 1'b0);
    idle(2);

    rst = 1'b1;
    #20;
    check("pulse_wren", 32'(WrEn), 32'd0);
    check("pulse_busw", 32'(busW), 32'd0);
    check("pulse_rw", 32'(Rw), 32'd0);
    check("pulse_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    idle(2);

    // MUL with the next op held on the bus through the stall.
    sendx(4'd10, 5'd7, 16'hFFFF, 16'hFFFD, 16'h0003, 1'b0);
    sendx(4'd0, 5'd8, 16'h0002, 16'h0003, 16'h0005, 1'b0);
    idle(2);

    // MUL aborted by reset: nothing expected from it.
    drive(4'd10, 5'd9, 16'd300, 16'd300, 1'b0, 1'b0, 16'd0, 1'b0);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #20;
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    sendx(4'd10, 5'd10, 16'd3, 16'd4, 16'd12, 1'b0);
    idle(2);

    sendx(4'd0, 5'd11, 16'h0010, 16'h0020, 16'h0030, 1'b0);
    send(4'd13, 5'd12, 16'h1234, 16'h5678);
    sendx(4'd0, 5'd13, 16'h8000, 16'h8000, 16'h0000, 1'b1);
    idle(2);
    check("reserved_hold_rw", 32'(Rw), 32'd13);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      send(o, 5'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(20);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
